// File: rtl/clock_gen.sv
// clock_gen: programmable divided clock generator.
// clk_out is a registered 50% duty clock whose half-period is half_reg clk
// cycles. rise_tick/fall_tick flag the first cycle after each edge of clk_out.
// Optional feature: define CLOCK_CYCLE_COUNTER_EN to add the 32-bit
// cycle_count port, which counts clk_out rising edges.
module clock_gen #(
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_HALF = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 clk_out,
  output logic                 rise_tick,
  output logic                 fall_tick
`ifdef CLOCK_CYCLE_COUNTER_EN
  ,
  output logic [31:0]          cycle_count
`endif
);

  localparam logic [DIV_WIDTH-1:0] ONE        = DIV_WIDTH'(1);
  localparam int                   RST_HALF_I = (DEFAULT_HALF < 1) ? 1 : DEFAULT_HALF;
  localparam logic [DIV_WIDTH-1:0] RST_HALF   = RST_HALF_I[DIV_WIDTH-1:0];

  // A half-period of zero is meaningless; treat it as the shortest legal one.
  function automatic logic [DIV_WIDTH-1:0] clamp_half(input logic [DIV_WIDTH-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clk_out_q, clk_out_d;
  logic                 rise_tick_q, rise_tick_d;
  logic                 fall_tick_q, fall_tick_d;
  logic                 term_cnt;
`ifdef CLOCK_CYCLE_COUNTER_EN
  logic [31:0]          cycle_count_q, cycle_count_d;
`endif

  // Terminal count: the current phase ends this cycle.
  assign term_cnt = (cnt_q == (half_q - ONE));

  // Next-state logic: load restarts the phase and beats any toggle; en=0 freezes.
  always_comb begin
    half_d      = half_q;
    cnt_d       = cnt_q;
    clk_out_d   = clk_out_q;
    rise_tick_d = 1'b0;
    fall_tick_d = 1'b0;
`ifdef CLOCK_CYCLE_COUNTER_EN
    cycle_count_d = cycle_count_q;
`endif
    if (load) begin
      half_d    = clamp_half(half_period);
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (en) begin
      if (term_cnt) begin
        cnt_d       = '0;
        clk_out_d   = ~clk_out_q;
        rise_tick_d = ~clk_out_q;
        fall_tick_d = clk_out_q;
`ifdef CLOCK_CYCLE_COUNTER_EN
        if (!clk_out_q) cycle_count_d = cycle_count_q + 32'd1;
`endif
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers with synchronous reset, which overrides load and en.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q      <= RST_HALF;
      cnt_q       <= '0;
      clk_out_q   <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
`ifdef CLOCK_CYCLE_COUNTER_EN
      cycle_count_q <= 32'd0;
`endif
    end else begin
      half_q      <= half_d;
      cnt_q       <= cnt_d;
      clk_out_q   <= clk_out_d;
      rise_tick_q <= rise_tick_d;
      fall_tick_q <= fall_tick_d;
`ifdef CLOCK_CYCLE_COUNTER_EN
      cycle_count_q <= cycle_count_d;
`endif
    end
  end

  assign clk_out   = clk_out_q;
  assign rise_tick = rise_tick_q;
  assign fall_tick = fall_tick_q;
`ifdef CLOCK_CYCLE_COUNTER_EN
  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Directed testbench for clock_gen (DIV_WIDTH=8, DEFAULT_HALF=1).
// Counter checks are compiled only when CLOCK_CYCLE_COUNTER_EN is defined.
module tb_clock_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] half_period;
  logic       clk_out;
  logic       rise_tick;
  logic       fall_tick;
`ifdef CLOCK_CYCLE_COUNTER_EN
  logic [31:0] cycle_count;
`endif

  int errors = 0;
  int checks = 0;

  clock_gen #(.DIV_WIDTH(8), .DEFAULT_HALF(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .load        (load),
    .half_period (half_period),
    .clk_out     (clk_out),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick)
`ifdef CLOCK_CYCLE_COUNTER_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clk cycle and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      $error("check %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check all three outputs at once.
  task automatic chk3(input string tag, input logic c, input logic r, input logic f);
    chk({tag, ".clk_out"}, clk_out, c);
    chk({tag, ".rise"}, rise_tick, r);
    chk({tag, ".fall"}, fall_tick, f);
  endtask

  logic exp_c3 [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic exp_r3 [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic exp_f3 [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; half_period = 8'd0;
    step(); step();
    chk3("reset", 1'b0, 1'b0, 1'b0);
`ifdef CLOCK_CYCLE_COUNTER_EN
    chk32("reset.count", cycle_count, 32'd0);
`endif

    // Default half of 1: toggle every cycle.
    reset = 1'b0; en = 1'b1;
    step(); chk3("def.e1", 1'b1, 1'b1, 1'b0);
    step(); chk3("def.e2", 1'b0, 1'b0, 1'b1);
    step(); chk3("def.e3", 1'b1, 1'b1, 1'b0);
    step(); chk3("def.e4", 1'b0, 1'b0, 1'b1);

    // Half period 3: low 3, high 3.
    load = 1'b1; half_period = 8'd3;
    step(); load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      chk3($sformatf("h3.%0d", i), exp_c3[i], exp_r3[i], exp_f3[i]);
    end

    // clk_out is now 1: load of 0 forces it low without a fall tick, then period 2.
    load = 1'b1; half_period = 8'd0;
    step(); load = 1'b0;
    chk3("h0.load", 1'b0, 1'b0, 1'b0);
    step(); chk3("h0.e1", 1'b1, 1'b1, 1'b0);
    step(); chk3("h0.e2", 1'b0, 1'b0, 1'b1);
    step(); chk3("h0.e3", 1'b1, 1'b1, 1'b0);

    // Half period 4, freeze 5 cycles in the high phase, then resume.
    load = 1'b1; half_period = 8'd4;
    step(); load = 1'b0;
    chk3("h4.load", 1'b0, 1'b0, 1'b0);
    step(); chk3("h4.e1", 1'b0, 1'b0, 1'b0);
    step(); chk3("h4.e2", 1'b0, 1'b0, 1'b0);
    step(); chk3("h4.e3", 1'b0, 1'b0, 1'b0);
    step(); chk3("h4.e4", 1'b1, 1'b1, 1'b0);
    step(); chk3("h4.e5", 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk3($sformatf("hold.%0d", i), 1'b1, 1'b0, 1'b0);
    end
    en = 1'b1;
    step(); chk3("res.e1", 1'b1, 1'b0, 1'b0);
    step(); chk3("res.e2", 1'b1, 1'b0, 1'b0);
    step(); chk3("res.e3", 1'b0, 1'b0, 1'b1);

    // Load in the terminal-count cycle: no toggle, phase restarts.
    step(); chk3("tc.e1", 1'b0, 1'b0, 1'b0);
    step(); chk3("tc.e2", 1'b0, 1'b0, 1'b0);
    step(); chk3("tc.e3", 1'b0, 1'b0, 1'b0);
    load = 1'b1; half_period = 8'd4;
    step(); load = 1'b0;
    chk3("tc.load", 1'b0, 1'b0, 1'b0);
    step(); chk3("tc.r1", 1'b0, 1'b0, 1'b0);
    step(); chk3("tc.r2", 1'b0, 1'b0, 1'b0);
    step(); chk3("tc.r3", 1'b0, 1'b0, 1'b0);
    step(); chk3("tc.r4", 1'b1, 1'b1, 1'b0);

    // Reset mid-phase together with load: reset wins, half returns to 1.
    step();
    reset = 1'b1; load = 1'b1; half_period = 8'd5;
    step(); reset = 1'b0; load = 1'b0;
    chk3("rst.load", 1'b0, 1'b0, 1'b0);
    step(); chk3("rst.e1", 1'b1, 1'b1, 1'b0);
    step(); chk3("rst.e2", 1'b0, 1'b0, 1'b1);

`ifdef CLOCK_CYCLE_COUNTER_EN
    // Half period 2 for 40 enabled cycles yields 10 rising edges.
    reset = 1'b1;
    step(); reset = 1'b0;
    load = 1'b1; half_period = 8'd2;
    step(); load = 1'b0;
    chk32("cnt.load", cycle_count, 32'd0);
    for (int i = 0; i < 40; i++) step();
    chk32("cnt.40", cycle_count, 32'd10);
    en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk32("cnt.hold", cycle_count, 32'd10);
    load = 1'b1; half_period = 8'd1;
    step(); load = 1'b0;
    chk32("cnt.loadkeep", cycle_count, 32'd10);
    en = 1'b1;
    step();
    chk32("cnt.inc", cycle_count, 32'd11);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk32("cnt.reset", cycle_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
